// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions: opcodes, fetch states, IF/ID bundle.
// Imported by the fetch stage and its IF/ID storage.
package fetch_stage_pkg;

  localparam logic [3:0] OPCODE_B   = 4'hC;
  localparam logic [3:0] OPCODE_BR  = 4'hD;
  localparam logic [3:0] OPCODE_HLT = 4'hF;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [15:0] instruction;
    logic [15:0] pc_plus_two;
  } if_id_t;

  function automatic logic is_hlt(
    input logic [3:0] opcode
  );
    return opcode == OPCODE_HLT;
  endfunction

  function automatic logic is_branch(
    input logic [3:0] opcode
  );
    return (opcode == OPCODE_B) ||
           (opcode == OPCODE_BR);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory read port between fetch and imem.
// Fetch owns the request; memory returns data/valid.
interface fetch_stage_if;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_data,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_data,
    output imem_valid
  );

endinterface

// File: rtl/fetch_stage_if_id_latch.sv
// IF/ID pipeline register: load, bubble-clear, or hold.
// Clear only kills the valid bit; payload is left as is.
module if_id_latch
  import fetch_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   enable,
  input  logic   clear,
  input  if_id_t fetched,
  output if_id_t stage,
  output logic   valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (enable) begin
      stage <= fetched;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: imem request, one-entry skid, HLT stop.
// Drives pc_enable so pc_register advances once per delivery.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc,
  input  logic [15:0] pc_plus_two,
  input  logic        stall,
  input  logic        flush,
  fetch_stage_if.master imem,
  output logic        pc_enable,
  output logic [15:0] if_id_instruction,
  output logic [15:0] if_id_pc_plus_two,
  output logic        if_id_valid,
  output logic        halted
);

  fetch_state_e state;
  fetch_state_e state_nxt;

  if_id_t skid;
  if_id_t fetched;
  if_id_t load_word;
  if_id_t stage;

  logic req;
  logic load;
  logic skid_load;
  logic clear;
  logic hlt;

  assign fetched = '{
    instruction: imem.imem_data,
    pc_plus_two: pc_plus_two
  };

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    load      = 1'b0;
    skid_load = 1'b0;
    load_word = fetched;
    unique case (state)
      FETCH: begin
        req = !flush;
        if (!flush && imem.imem_valid) begin
          if (stall) begin
            skid_load = 1'b1;
            state_nxt = HOLD;
          end else begin
            load = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!flush && !stall) begin
          load      = 1'b1;
          load_word = skid;
        end
      end
      HALT: begin
      end
      default: begin
      end
    endcase
    hlt = is_hlt(load_word.instruction[15:12]);
    if (load) begin
      state_nxt = hlt ? HALT : FETCH;
    end
    if (flush) begin
      state_nxt = FETCH;
    end
    // Any cycle without a load and without stall is a bubble.
    clear = flush | (!stall & !load);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid <= '0;
    end else if (flush) begin
      skid <= '0;
    end else if (skid_load) begin
      skid <= fetched;
    end
  end

  if_id_latch u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (load),
    .clear   (clear),
    .fetched (load_word),
    .stage   (stage),
    .valid   (if_id_valid)
  );

  assign imem.imem_req  = req & rst_n;
  assign imem.imem_addr = pc;

  assign pc_enable = load & !hlt & rst_n;
  assign halted    = (state == HALT);

  assign if_id_instruction = stage.instruction;
  assign if_id_pc_plus_two = stage.pc_plus_two;

endmodule
